// File: rtl/instr_loader.sv
// Program loader: collects little-endian bytes from a host link, writes 32-bit words
// into instruction memory, and holds the core in reset until the image is complete.
module instr_loader #(
    parameter int PC_SIZE = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PC_SIZE:0]   word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               rw,
    output logic [PC_SIZE-1:0] PC_write,
    output logic [31:0]        instruction_in,
    output logic               reset_IF_memory,
    output logic               cpu_reset_n,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RECV  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Largest legal count is a full memory image of 2^PC_SIZE words.
    localparam logic [PC_SIZE:0] MAX_WORDS = {1'b1, {PC_SIZE{1'b0}}};

    state_t             state, state_next;
    logic [PC_SIZE:0]   count_q;
    logic [PC_SIZE:0]   addr_q;
    logic [31:0]        word_q;
    logic [1:0]         byte_idx;
    logic               error_q;

    logic               in_busy;
    logic               start_take;
    logic               count_ok;
    logic               byte_take;
    logic               abort_take;
    logic               last_word;

    // Byte link handshake: a byte transfers on a rising edge where byte_valid and
    // byte_ready are both high; the host holds byte_in stable while waiting.
    always_comb begin
        in_busy    = (state == CLEAR) || (state == RECV) || (state == WRITE);
        abort_take = abort && in_busy;
        start_take = start && !abort && ((state == IDLE) || (state == DONE));
        count_ok   = (word_count <= MAX_WORDS);
        byte_take  = (state == RECV) && byte_valid && !abort;
        last_word  = ((addr_q + 1'b1) == count_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_take) begin
                    state_next = count_ok ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                state_next = (count_q == '0) ? DONE : RECV;
            end
            RECV: begin
                if (byte_take && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
        if (abort_take) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            byte_idx <= '0;
            error_q  <= 1'b0;
        end else if (abort_take) begin
            // Partial bytes are dropped so a later load starts from a clean word.
            word_q   <= '0;
            byte_idx <= '0;
            error_q  <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_take) begin
                        if (count_ok) begin
                            count_q <= word_count;
                            error_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    addr_q   <= '0;
                    word_q   <= '0;
                    byte_idx <= '0;
                end
                RECV: begin
                    if (byte_take) begin
                        word_q[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx                        <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    addr_q <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The address register carries one extra bit so a full image never wraps it.
    always_comb begin
        byte_ready      = (state == RECV);
        rw              = (state == WRITE) && !abort;
        PC_write        = addr_q[PC_SIZE-1:0];
        instruction_in  = word_q;
        reset_IF_memory = (state == CLEAR);
        cpu_reset_n     = (state == DONE);
        done            = (state == DONE);
        busy            = in_busy;
        error           = error_q;
        state_dbg       = state;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized bench for instr_loader: a byte-list reference model builds
// the expected memory writes, which are matched against writes seen on rw.
module tb_instr_loader;

    localparam int PC_SIZE = 10;
    localparam int AW      = PC_SIZE + 32;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [PC_SIZE:0]   word_count = '0;
    logic [7:0]         byte_in = '0;
    logic               byte_valid = 1'b0;
    logic               byte_ready;
    logic               rw;
    logic [PC_SIZE-1:0] PC_write;
    logic [31:0]        instruction_in;
    logic               reset_IF_memory;
    logic               cpu_reset_n;
    logic               busy;
    logic               done;
    logic               error;
    logic [2:0]         state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;
    int rw_cnt   = 0;

    logic [AW-1:0] act_q[$];
    logic [AW-1:0] exp_q[$];
    logic [7:0]    byte_q[$];

    instr_loader #(.PC_SIZE(PC_SIZE)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .word_count      (word_count),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .rw              (rw),
        .PC_write        (PC_write),
        .instruction_in  (instruction_in),
        .reset_IF_memory (reset_IF_memory),
        .cpu_reset_n     (cpu_reset_n),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .state_dbg       (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor on the falling edge, away from the edge that updates the DUT.
    always @(negedge clock) begin
        if (rw) begin
            act_q.push_back({PC_write, instruction_in});
            rw_cnt++;
        end
        if (reset_IF_memory) clr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [PC_SIZE:0] cnt);
        word_count = cnt;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit taken = 0;
        byte_valid = 1'b0;
        tick($urandom_range(max_gap, 0));
        byte_valid = 1'b1;
        byte_in    = b;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (byte_ready) begin
                taken = 1;
                break;
            end
        end
        if (taken) begin
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b0;
        check("byte_accept", 64'(taken), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            tick(1);
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Reference model: word i is bytes 4i..4i+3, first byte least significant, at address i.
    task automatic build_expected(input int cnt);
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] w;
            w = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
            exp_q.push_back({PC_SIZE'(i), w});
        end
    endtask

    task automatic compare_writes(input int act_base);
        int n_act;
        n_act = act_q.size() - act_base;
        check("wr_count", 64'(n_act), 64'(exp_q.size()));
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            if (i < n_act) check("wr_data", 64'(act_q[act_base + i]), 64'(e));
        end
    endtask

    task automatic run_load(input int cnt, input int max_gap);
        int act_base;
        int clr_base;
        act_base = act_q.size();
        clr_base = clr_cnt;
        build_expected(cnt);
        pulse_start(cnt[PC_SIZE:0]);
        for (int i = 0; i < 4 * cnt; i++) send_byte(byte_q[i], max_gap);
        wait_done("load_done");
        tick(1);
        compare_writes(act_base);
        check("load_clear_pulses", 64'(clr_cnt - clr_base), 64'd1);
        check("load_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
        check("load_busy", 64'(busy), 64'd0);
        check("load_error", 64'(error), 64'd0);
    endtask

    task automatic random_bytes(input int cnt);
        byte_q.delete();
        for (int i = 0; i < 4 * cnt; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_rw"}, 64'(rw), 64'd0);
        check({tag, "_pc_write"}, 64'(PC_write), 64'd0);
        check({tag, "_instr"}, 64'(instruction_in), 64'd0);
        check({tag, "_clr"}, 64'(reset_IF_memory), 64'd0);
        check({tag, "_cpu_reset_n"}, 64'(cpu_reset_n), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int base;
        int clr_base;
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};

        // Reset state
        #3 reset = 1'b0;
        tick(3);
        check_all_zero("rst");
        reset = 1'b1;
        tick(2);
        check("idle_busy", 64'(busy), 64'd0);

        // Two-word known program, no gaps
        byte_q.delete();
        foreach (prog[i]) byte_q.push_back(prog[i]);
        run_load(2, 0);

        // Same program with random byte_valid gaps, started from DONE
        byte_q.delete();
        foreach (prog[i]) byte_q.push_back(prog[i]);
        run_load(2, 5);

        // Zero-length load
        base     = act_q.size();
        clr_base = clr_cnt;
        word_count = '0;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        check("zero_clear_now", 64'(reset_IF_memory), 64'd1);
        check("zero_done_early", 64'(done), 64'd0);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_cpu_held", 64'(cpu_reset_n), 64'd0);
        tick(1);
        check("zero_done", 64'(done), 64'd1);
        check("zero_cpu_run", 64'(cpu_reset_n), 64'd1);
        tick(1);
        check("zero_clear_pulses", 64'(clr_cnt - clr_base), 64'd1);
        check("zero_no_rw", 64'(act_q.size() - base), 64'd0);

        // Abort after two bytes
        base = act_q.size();
        pulse_start(2);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_error", 64'(error), 64'd1);
        check("abort_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick(6);
        check("abort_no_rw", 64'(act_q.size() - base), 64'd0);
        check("abort_stays_idle", 64'(busy), 64'd0);

        // Abort landing on the write cycle suppresses the strobe
        base = act_q.size();
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1);
        abort = 1'b1;
        @(negedge clock);
        check("abort_write_rw", 64'(rw), 64'd0);
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_write_error", 64'(error), 64'd1);
        check("abort_write_busy", 64'(busy), 64'd0);
        tick(2);
        check("abort_write_no_rw", 64'(act_q.size() - base), 64'd0);

        // A load after abort must not carry leftover bytes
        random_bytes(2);
        run_load(2, 2);

        // Oversized count is rejected from DONE
        base     = act_q.size();
        clr_base = clr_cnt;
        pulse_start(11'd1025);
        for (int i = 0; i < 3; i++) begin
            check("big_busy", 64'(busy), 64'd0);
            tick(1);
        end
        check("big_error", 64'(error), 64'd1);
        check("big_done", 64'(done), 64'd0);
        check("big_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        check("big_no_clear", 64'(clr_cnt - clr_base), 64'd0);
        check("big_no_rw", 64'(act_q.size() - base), 64'd0);

        // Reset during RECV
        pulse_start(2);
        send_byte(8'h77, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(posedge clock);
        #1 reset = 1'b1;
        tick(3);
        check("post_rst_idle", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        random_bytes(3);
        run_load(3, 3);

        // Randomized loads back to back
        for (int r = 0; r < 5; r++) begin
            int cnt;
            cnt = $urandom_range(6, 1);
            random_bytes(cnt);
            run_load(cnt, $urandom_range(3, 0));
        end

        // Full-size image reaches the last address without wrapping
        random_bytes(1024);
        run_load(1024, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
